// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide sequencer.
//   - op encodings (op[1:0]; op[2] selects signed divide when MULDIV_SIGNED_EN is defined)
//   - sequencer state enum
//   - ALU operation codes, shared with the ALU decoder
//   - abs_val helper used by the signed-divide front end
package muldiv_pkg;

  localparam int MD_W = 32;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL     = 3'd1,
    S_DIV_CMP = 3'd2,
    S_DIV_SUB = 3'd3,
    S_FIX     = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Two's-complement magnitude; -2^31 maps to 0x80000000, which is the
  // correct unsigned magnitude for the divider.
  function automatic logic [MD_W-1:0] abs_val(input logic [MD_W-1:0] v);
    return v[MD_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_cnt.sv
// muldiv_cnt: iteration counter for the multiply/divide sequencer.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   clr    - synchronous clear to zero (wins over en)
//   en     - advance by one
//   last_o - high while the count is at its final value (all ones)
module muldiv_cnt #(
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = &cnt_q;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MUL / MULHU / DIVU / REMU sequencer that borrows the
// shared ALU while busy. Optional signed divide enabled by macro
// MULDIV_SIGNED_EN (op[2]=1 on a divide op selects DIV/REM).
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   start, kill       - launch request (IDLE only); flush, outranks start
//   op, src_a, src_b  - operation and operands
//   busy, done        - busy from cycle after start until DONE; done pulse
//   result            - final value, held until rewritten by the next op
//   alu_own           - ALU mux select (equals busy)
//   alu_op1/op2/ctrl  - ALU operands/opcode, zero when alu_own=0
//   alu_res           - combinational ALU result
// Latency start->done: MUL/MULHU 33, DIVU/REMU 65, signed divide 66, /0 1.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_own,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_res
);

  state_e            state_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;
  logic [1:0]        op_q;
  // acc_q: product high half / partial remainder.
  // sh_q : multiplier shifting into product low half / dividend shifting into quotient.
  // opb_q: multiplicand / divisor.
  logic [XLEN-1:0]   acc_q, sh_q, opb_q;
  logic              cnt_last;

  logic              carry;
  logic [XLEN-1:0]   mul_hi_d, mul_lo_d, rem_shift_d, rem_sub_d, div_res_d;
  logic              ovf, qbit;

`ifdef MULDIV_SIGNED_EN
  logic              fix_q, neg_q;
  logic [XLEN-1:0]   fix_val;
  assign fix_val = op_q[0] ? acc_q : sh_q;
`else
  logic              unused_op2;
  assign unused_op2 = op[2];
`endif

  muldiv_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == S_IDLE),
    .en     ((state_q == S_MUL) || (state_q == S_DIV_SUB)),
    .last_o (cnt_last)
  );

  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = '0;
    case (state_q)
      S_MUL: begin
        alu_op1  = acc_q;
        alu_op2  = sh_q[0] ? opb_q : '0;
        alu_ctrl = ALU_ADD;
      end
      S_DIV_CMP: begin
        alu_op1  = rem_shift_d;
        alu_op2  = opb_q;
        alu_ctrl = ALU_SLTU;
      end
      S_DIV_SUB: begin
        alu_op1  = acc_q;
        alu_op2  = opb_q;
        alu_ctrl = ALU_SUB;
      end
`ifdef MULDIV_SIGNED_EN
      S_FIX: begin
        alu_op1  = '0;
        alu_op2  = fix_val;
        alu_ctrl = ALU_SUB;
      end
`endif
      default: ;
    endcase
  end

  // Carry out of the add is recovered from unsigned wrap-around.
  assign carry       = alu_res < alu_op1;
  assign mul_hi_d    = {carry, alu_res[XLEN-1:1]};
  assign mul_lo_d    = {alu_res[0], sh_q[XLEN-1:1]};
  assign rem_shift_d = {acc_q[XLEN-2:0], sh_q[XLEN-1]};
  // ovf: the bit shifted out of rem makes it >= any divisor.
  assign ovf         = acc_q[XLEN-1];
  assign qbit        = ovf | ~alu_res[0];
  // The quotient bit just shifted in sits in sh_q[0] during DIV_SUB.
  assign rem_sub_d   = sh_q[0] ? alu_res : acc_q;
  assign div_res_d   = op_q[0] ? rem_sub_d : sh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !kill) begin
              op_q  <= op[1:0];
              acc_q <= '0;
              if (op[1]) begin
`ifdef MULDIV_SIGNED_EN
                fix_q <= op[2];
                neg_q <= op[0] ? src_a[XLEN-1] : (src_a[XLEN-1] ^ src_b[XLEN-1]);
                sh_q  <= op[2] ? abs_val(src_a) : src_a;
                opb_q <= op[2] ? abs_val(src_b) : src_b;
`else
                sh_q  <= src_a;
                opb_q <= src_b;
`endif
              end else begin
                sh_q  <= src_b;
                opb_q <= src_a;
              end
              if (op[1] && (src_b == '0)) begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                result_q <= op[0] ? src_a : '1;
              end else begin
                state_q <= op[1] ? S_DIV_CMP : S_MUL;
                busy_q  <= 1'b1;
              end
            end
          end
          S_MUL: begin
            acc_q <= mul_hi_d;
            sh_q  <= mul_lo_d;
            if (cnt_last) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= op_q[0] ? mul_hi_d : mul_lo_d;
            end
          end
          S_DIV_CMP: begin
            acc_q   <= rem_shift_d;
            sh_q    <= {sh_q[XLEN-2:0], qbit};
            state_q <= S_DIV_SUB;
          end
          S_DIV_SUB: begin
            acc_q <= rem_sub_d;
            if (cnt_last) begin
`ifdef MULDIV_SIGNED_EN
              if (fix_q) begin
                state_q <= S_FIX;
              end else begin
                state_q  <= S_DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                result_q <= div_res_d;
              end
`else
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= div_res_d;
`endif
            end else begin
              state_q <= S_DIV_CMP;
            end
          end
`ifdef MULDIV_SIGNED_EN
          S_FIX: begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= neg_q ? alu_res : fix_val;
          end
`endif
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign alu_own = busy_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq, including a
// behavioural model of the shared ALU.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, alu_own;
  logic [31:0] result, alu_op1, alu_op2, alu_res;
  logic [3:0]  alu_ctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Shared ALU model
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_res = alu_op1 + alu_op2;
      4'b0001: alu_res = alu_op1 - alu_op2;
      4'b0011: alu_res = {31'b0, alu_op1 < alu_op2};
      default: alu_res = 32'h0;
    endcase
  end

  muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kill     (kill),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .alu_own  (alu_own),
    .alu_op1  (alu_op1),
    .alu_op2  (alu_op2),
    .alu_ctrl (alu_ctrl),
    .alu_res  (alu_res)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one op from IDLE (called just after a rising edge) and follow it
  // to its done pulse. poke>0 re-asserts start (with scrambled src_a) on that
  // cycle of the operation, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input int poke);
    int cyc, busy_cnt, own_bad;
    bit got;
    op = o; src_a = a; src_b = b; start = 1'b1;
    cyc = 0; got = 0; busy_cnt = 0; own_bad = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) src_a = ~a;
      if (busy) busy_cnt++;
      if (alu_own !== busy) own_bad++;
      if (done) got = 1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, "_own_tracks_busy"}, 32'(own_bad), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dn;
    logic [31:0] prev;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_own", 32'(alu_own), 32'd0);
    check("rst_op1", alu_op1, 32'h0);
    check("rst_op2", alu_op2, 32'h0);
    check("rst_ctrl", 32'(alu_ctrl), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7x6",        3'b000, 32'd7,        32'd6,        33, 32'd42,        0);
    run_op("mul_7x6_op2",    3'b100, 32'd7,        32'd6,        33, 32'd42,        0);
    run_op("mulhu_ff",       3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE,  0);
    run_op("mul_ff",         3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001,  0);
    run_op("mul_2p16sq",     3'b000, 32'h00010000, 32'h00010000, 33, 32'h00000000,  0);
    run_op("mulhu_2p16sq",   3'b001, 32'h00010000, 32'h00010000, 33, 32'h00000001,  0);
    run_op("divu_100_7",     3'b010, 32'd100,      32'd7,        65, 32'd14,        0);
    run_op("remu_100_7",     3'b011, 32'd100,      32'd7,        65, 32'd2,         0);
    run_op("divu_ovf",       3'b010, 32'hFFFFFFFF, 32'h80000001, 65, 32'h00000001,  0);
    run_op("remu_ovf",       3'b011, 32'hFFFFFFFF, 32'h80000001, 65, 32'h7FFFFFFE,  0);
    run_op("remu_7_9",       3'b011, 32'd7,        32'd9,        65, 32'd7,         0);
    run_op("divu_5_0",       3'b010, 32'd5,        32'd0,         1, 32'hFFFFFFFF,  0);
    run_op("remu_5_0",       3'b011, 32'd5,        32'd0,         1, 32'd5,         0);
    run_op("mul_poke",       3'b000, 32'd3,        32'd5,        33, 32'd15,        5);
    run_op("remu_poke",      3'b011, 32'd100,      32'd7,        65, 32'd2,        20);

    // kill on cycle 10 of a multiply
    prev = result;
    op = 3'b001; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_own", 32'(alu_own), 32'd0);
    check("kill_op1", alu_op1, 32'h0);
    check("kill_ctrl", 32'(alu_ctrl), 32'd0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("kill_no_done", 32'(dn), 32'd0);
    check("kill_result_held", result, prev);

    // kill together with start in IDLE: start must not be accepted
    op = 3'b000; src_a = 32'd2; src_b = 32'd2; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("kill_start_idle", 32'(busy), 32'd0);

    run_op("mul_after_kill", 3'b000, 32'd9, 32'd9, 33, 32'd81, 0);

`ifdef MULDIV_SIGNED_EN
    run_op("div_m7_2",       3'b110, 32'hFFFFFFF9, 32'd2,        66, 32'hFFFFFFFD, 0);
    run_op("rem_m7_2",       3'b111, 32'hFFFFFFF9, 32'd2,        66, 32'hFFFFFFFF, 0);
    run_op("div_7_2",        3'b110, 32'd7,        32'd2,        66, 32'd3,        0);
    run_op("rem_7_m2",       3'b111, 32'd7,        32'hFFFFFFFE, 66, 32'd1,        0);
    run_op("div_min_m1",     3'b110, 32'h80000000, 32'hFFFFFFFF, 66, 32'h80000000, 0);
    run_op("rem_min_m1",     3'b111, 32'h80000000, 32'hFFFFFFFF, 66, 32'h00000000, 0);
    run_op("div_m5_0",       3'b110, 32'hFFFFFFFB, 32'd0,         1, 32'hFFFFFFFF, 0);
    run_op("rem_m5_0",       3'b111, 32'hFFFFFFFB, 32'd0,         1, 32'hFFFFFFFB, 0);
`else
    run_op("divu_op2_ign",   3'b110, 32'hFFFFFFF9, 32'd2,        65, 32'h7FFFFFFC, 0);
    run_op("remu_op2_ign",   3'b111, 32'hFFFFFFF9, 32'd2,        65, 32'h00000001, 0);
`endif

    // reset in the middle of an operation
    op = 3'b000; src_a = 32'd7; src_b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_own", 32'(alu_own), 32'd0);
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_op1", alu_op1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that borrows the shared 32-bit ALU (add/sub/sltu) to run MUL, MULHU, DIVU and REMU over many cycles.
- Sits beside the EX stage and raises busy so the hazard unit stalls the pipeline.
- Owns the ALU operand/control mux while alu_own=1.

Parameters:
XLEN, 32, operand/result width; only 32 supported.
CNT_W, 5, iteration counter width, log2(XLEN).
ALU_ADD, 4'b0000, ALU add code.
ALU_SUB, 4'b0001, ALU subtract code.
ALU_SLTU, 4'b0011, ALU unsigned less-than code.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  launch request; sampled only in IDLE.
kill  in  1  pipeline flush; aborts any operation.
op  in  3  [1:0]: 00 MUL low, 01 MULHU, 10 DIVU, 11 REMU; [2] signed (see feature).
src_a  in  32  multiplicand / dividend.
src_b  in  32  multiplier / divisor.
busy  out  1  high from cycle after accepted start until DONE.
done  out  1  one-cycle pulse in DONE; result valid.
result  out  32  final value; held until next accepted start.
alu_own  out  1  ALU mux select to this block; equals busy.
alu_op1  out  32  ALU operand 1.
alu_op2  out  32  ALU operand 2.
alu_ctrl  out  4  ALU operation code.
alu_res  in  32  ALU combinational result, same cycle.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, alu_own=0. Drive alu_op1, alu_op2 and alu_ctrl to 0 whenever alu_own=0.
- States: IDLE, MUL, DIV_CMP, DIV_SUB, FIX (feature only), DONE.
- IDLE, start=1:
  - Latch operands and op; clear the 5-bit counter.
  - Next state is MUL for op 00/01, DIV_CMP for 10/11.
  - If a divide has src_b==0, go directly to DONE: DIVU gives 0xFFFFFFFF, REMU gives src_a.
- MUL (one cycle per iteration, 32 iterations):
  - ALU computes hi + (lo[0] ? mcand : 0) using ALU_ADD.
  - carry = (alu_res < alu_op1), computed locally.
  - Update {hi,lo} <= {carry, alu_res, lo} >> 1.
  - Exit to DONE when counter==31.
- DIV_CMP:
  - rem <= {rem[30:0], dividend msb}, with the old rem[31] kept in flag ovf.
  - ALU_SLTU compares the shifted rem against the divisor.
  - Quotient bit = ovf | ~alu_res, shifted into quo.
- DIV_SUB:
  - ALU_SUB computes rem - divisor; write it back only if the quotient bit is 1.
  - Wrap-around is correct when ovf=1.
  - Counter==31 goes to DONE (or FIX); otherwise back to DIV_CMP.
- DONE: done=1 and result valid for one cycle; next state IDLE.
- Latency from start cycle to done cycle: MUL/MULHU 33, DIVU/REMU 65, divide by zero 1.
- start while busy: ignored.
- kill in any non-IDLE state: next state IDLE; no done; result unchanged. kill outranks start in the same cycle.
- rst mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- With the macro defined, op[2]=1 on DIVU/REMU selects signed DIV/REM:
  - Operands are absolute-valued locally at start.
  - One extra FIX state negates the result via ALU_SUB (0 - r): quotient when the signs differ, remainder when the dividend is negative.
  - Signed divides always take 66 cycles.
  - Divide by zero: quotient 0xFFFFFFFF, remainder src_a, no FIX.
  - -2^31 / -1 gives 0x80000000, remainder 0.
- Without the macro, op[2] is ignored and FIX is absent.
- op[2] has no effect on MUL/MULHU in either build.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings;
  - the state enum;
  - ALU code constants, shared with the ALU decoder.
- One natural sub-module: muldiv_cnt, the 5-bit iteration counter with clear/enable and a last flag.

Test Plan:
- MUL 7 x 6 -> done exactly 33 cycles after start, result=42; busy high for 32 cycles; alu_own tracks busy.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2 at cycle 65; DIVU 0xFFFFFFFF/0x80000001 -> 1, REMU -> 0x7FFFFFFE (exercises ovf).
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done one cycle after start.
- kill on cycle 10 of MUL -> busy=0 and alu_own=0 next cycle, no done pulse, result unchanged; start asserted mid-op is ignored; a new start afterwards completes normally.
- With MULDIV_SIGNED_EN: DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, done at cycle 66; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
